// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction prefetch FIFO with redirect flush; FETCH_BYPASS_EN adds same-cycle bypass from memory to the head
module fetch_queue #(
  parameter int N = 32,
  parameter int DEPTH = 4,
  parameter logic [N-1:0] PC_START = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         redirect_i,
  input  logic [N-1:0] redirect_addr_i,
  output logic         mem_req_o,
  output logic [N-1:0] mem_addr_o,
  input  logic         mem_ack_i,
  input  logic [N-1:0] mem_rd_data_i,
  output logic         instr_valid_o,
  output logic [N-1:0] instr_o,
  output logic [N-1:0] instr_pc_o,
  input  logic         instr_take_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;
  state_t state_q, state_d;
  logic [N-1:0] fetch_pc_q, fetch_pc_d, mem_addr_q, mem_addr_d;
  logic mem_req_q;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [N-1:0] data_q [DEPTH];
  logic [N-1:0] pc_q [DEPTH];
  logic ack_ok, bypass, enq, deq;
  assign ack_ok = state_q == REQ && mem_ack_i;
`ifdef FETCH_BYPASS_EN
  assign bypass = ack_ok && count_q == '0;
`else
  assign bypass = 1'b0;
`endif
  // a bypassed word that is taken the same cycle never lands in the FIFO
  assign enq = ack_ok && !redirect_i && !(bypass && instr_take_i);
  assign deq = instr_take_i && count_q != '0 && !redirect_i;
  assign count_d = redirect_i ? '0 : count_q + CW'(enq) - CW'(deq);
  always_comb begin
    state_d = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    if (redirect_i) begin
      fetch_pc_d = {redirect_addr_i[N-1:2], 2'b00};
      state_d = (state_q == IDLE || mem_ack_i) ? REQ : DISCARD;
      if (state_d == REQ) mem_addr_d = fetch_pc_d;
    end else begin
      case (state_q)
        IDLE: if (count_d < FULL) begin
          state_d = REQ;
          mem_addr_d = fetch_pc_q;
        end
        REQ: if (mem_ack_i) begin
          fetch_pc_d = fetch_pc_q + N'(4);
          mem_addr_d = fetch_pc_d;
          state_d = (count_d < FULL) ? REQ : IDLE;
        end
        DISCARD: if (mem_ack_i) begin
          state_d = REQ;
          mem_addr_d = fetch_pc_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fetch_pc_q <= PC_START;
      mem_addr_q <= PC_START;
      mem_req_q <= 1'b0;
      count_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q <= state_d != IDLE;
      count_q <= count_d;
      if (redirect_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (enq) begin
          data_q[wr_ptr_q] <= mem_rd_data_i;
          pc_q[wr_ptr_q] <= mem_addr_q;
          wr_ptr_q <= wr_ptr_q + AW'(1);
        end
        if (deq) rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end
  assign mem_req_o = mem_req_q;
  assign mem_addr_o = mem_addr_q;
  assign instr_valid_o = bypass || count_q != '0;
  assign instr_o = bypass ? mem_rd_data_i : data_q[rd_ptr_q];
  assign instr_pc_o = bypass ? mem_addr_q : pc_q[rd_ptr_q];
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus randomized run against a queue-based fetch model
module tb_fetch_queue;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, redirect = 0, mem_ack = 0, instr_take = 0;
  logic [31:0] redirect_addr = 0, mem_rd_data = 0;
  logic mem_req, instr_valid;
  logic [31:0] mem_addr, instr, instr_pc;
  int n_cmp = 0, n_err = 0;
  logic pre_valid;
  logic [31:0] pre_instr, pre_pc;
  logic [63:0] m_q[$];
  logic m_req, m_stale;
  logic [31:0] m_addr, m_pc;
  fetch_queue #(.N(32), .DEPTH(DEPTH), .PC_START(32'h0)) dut (
    .clk(clk), .rst(rst), .redirect_i(redirect), .redirect_addr_i(redirect_addr),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_ack_i(mem_ack),
    .mem_rd_data_i(mem_rd_data), .instr_valid_o(instr_valid), .instr_o(instr),
    .instr_pc_o(instr_pc), .instr_take_i(instr_take)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] fdat(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction
  task automatic tick(input logic take, input logic ack, input logic redir,
                      input logic [31:0] raddr, input logic [31:0] data);
    logic ack_eff, byp;
    instr_take = take; mem_ack = ack; redirect = redir; redirect_addr = raddr; mem_rd_data = data;
    if (rst) begin
      m_q.delete(); m_req = 0; m_stale = 0; m_addr = 0; m_pc = 0;
    end else begin
      ack_eff = ack && m_req;
      if (redir) begin
        m_q.delete();
        m_pc = {raddr[31:2], 2'b00};
        if (!m_req || ack_eff) begin m_req = 1; m_addr = m_pc; m_stale = 0; end
        else m_stale = 1;
      end else begin
        byp = 0;
`ifdef FETCH_BYPASS_EN
        byp = ack_eff && !m_stale && m_q.size() == 0 && take;
`endif
        if (take && m_q.size() > 0) void'(m_q.pop_front());
        if (ack_eff && !m_stale) begin
          if (!byp) m_q.push_back({m_addr, data});
          m_pc = m_addr + 4;
          m_req = m_q.size() < DEPTH;
          m_addr = m_pc;
        end else if (ack_eff) begin
          m_stale = 0; m_addr = m_pc;
        end else if (!m_req && m_q.size() < DEPTH) begin
          m_req = 1; m_addr = m_pc;
        end
      end
    end
    #1;
    pre_valid = instr_valid; pre_instr = instr; pre_pc = instr_pc;
    @(posedge clk); #1;
    instr_take = 0; mem_ack = 0; redirect = 0;
    #1;
  endtask
  task automatic do_reset();
    rst = 1;
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    rst = 0;
  endtask
  task automatic test_reset();
    do_reset();
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %0h want 0", mem_req); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got %0h want 0", mem_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0h want 0", instr_valid); end
    n_cmp++; if (instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got %0h want 0", instr); end
    n_cmp++; if (instr_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %0h want 0", instr_pc); end
    tick(0, 0, 0, 0, 0);
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL first_req got %0h want 1", mem_req); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL first_addr got %0h want 0", mem_addr); end
  endtask
  task automatic test_fill();
    do_reset();
    tick(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'(4 * i)) begin
        n_err++; $display("FAIL fill_addr req %0h addr %0h want 1 %0h", mem_req, mem_addr, 4 * i);
      end
      tick(0, 1, 0, 0, fdat(32'(4 * i)));
    end
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL full_req got %0h want 0", mem_req); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * i) || instr !== fdat(32'(4 * i))) begin
        n_err++; $display("FAIL pop_head v %0h pc %0h instr %0h want 1 %0h %0h", instr_valid, instr_pc, instr, 4 * i, fdat(32'(4 * i)));
      end
      tick(1, 0, 0, 0, 0);
      if (i == 0) begin
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
          n_err++; $display("FAIL refill_req req %0h addr %0h want 1 10", mem_req, mem_addr);
        end
      end
    end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL drained_valid got %0h want 0", instr_valid); end
  endtask
  task automatic test_stream();
    logic [31:0] exp_pc;
    int n_pop;
    do_reset();
    tick(0, 0, 0, 0, 0);
    exp_pc = 0; n_pop = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1, mem_req, 0, 0, 32'h00000013);
      if (pre_valid) begin
        n_cmp++; if (pre_instr !== 32'h13 || pre_pc !== exp_pc) begin
          n_err++; $display("FAIL stream_word instr %0h pc %0h want 13 %0h", pre_instr, pre_pc, exp_pc);
        end
        exp_pc += 4; n_pop++;
      end
    end
    n_cmp++; if (n_pop < 10) begin n_err++; $display("FAIL stream_rate got %0d want >=10", n_pop); end
  endtask
  task automatic test_redirect_stale();
    do_reset();
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 1, 32'h00000103, 0);
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      n_err++; $display("FAIL stale_hold req %0h addr %0h want 1 0", mem_req, mem_addr);
    end
    tick(0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 32'hDEADBEEF);
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL stale_drop got %0h want 0", instr_valid); end
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      n_err++; $display("FAIL stale_newaddr req %0h addr %0h want 1 100", mem_req, mem_addr);
    end
    tick(0, 1, 0, 0, 32'h12345678);
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== 32'h12345678) begin
      n_err++; $display("FAIL stale_next v %0h pc %0h instr %0h want 1 100 12345678", instr_valid, instr_pc, instr);
    end
  endtask
  task automatic test_redirect_ack_take();
    do_reset();
    tick(0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, fdat(0));
    tick(0, 1, 0, 0, fdat(4));
    tick(1, 1, 1, 32'h00000200, fdat(8));
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rat_flush got %0h want 0", instr_valid); end
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
      n_err++; $display("FAIL rat_addr req %0h addr %0h want 1 200", mem_req, mem_addr);
    end
    tick(0, 0, 0, 0, 0);
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rat_noenq got %0h want 0", instr_valid); end
    tick(0, 1, 0, 0, fdat(32'h200));
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin
      n_err++; $display("FAIL rat_next v %0h pc %0h want 1 200", instr_valid, instr_pc);
    end
  endtask
  task automatic test_wrap();
    do_reset();
    tick(0, 0, 0, 0, 0);
    tick(0, 1, 1, 32'hFFFFFFFC, 32'h0BAD0BAD);
    tick(0, 1, 0, 0, 32'hAAAA0001);
    tick(0, 1, 0, 0, 32'hAAAA0002);
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFFFFFC || instr !== 32'hAAAA0001) begin
      n_err++; $display("FAIL wrap_first v %0h pc %0h instr %0h want 1 fffffffc aaaa0001", instr_valid, instr_pc, instr);
    end
    n_cmp++; if (mem_addr !== 32'h4) begin n_err++; $display("FAIL wrap_addr got %0h want 4", mem_addr); end
    tick(1, 0, 0, 0, 0);
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'hAAAA0002) begin
      n_err++; $display("FAIL wrap_second v %0h pc %0h instr %0h want 1 0 aaaa0002", instr_valid, instr_pc, instr);
    end
  endtask
  task automatic test_bypass_latency();
    do_reset();
    tick(0, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 32'hC0FFEE01);
`ifdef FETCH_BYPASS_EN
    n_cmp++; if (pre_valid !== 1'b1 || pre_instr !== 32'hC0FFEE01 || pre_pc !== 32'h0) begin
      n_err++; $display("FAIL byp_same v %0h instr %0h pc %0h want 1 c0ffee01 0", pre_valid, pre_instr, pre_pc);
    end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL byp_count got %0h want 0", instr_valid); end
`else
    n_cmp++; if (pre_valid !== 1'b0) begin n_err++; $display("FAIL nobyp_same got %0h want 0", pre_valid); end
    n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'hC0FFEE01 || instr_pc !== 32'h0) begin
      n_err++; $display("FAIL nobyp_next v %0h instr %0h pc %0h want 1 c0ffee01 0", instr_valid, instr, instr_pc);
    end
`endif
  endtask
  task automatic test_random();
    logic [63:0] hd;
    logic ack;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom % 97) == 0;
      ack = mem_req ? ($urandom % 3 != 0) : ($urandom % 8 == 0);
      tick($urandom % 2 == 0, ack, $urandom % 14 == 0, $urandom, fdat(mem_addr));
      rst = 0;
      n_cmp++; if (mem_req !== m_req) begin n_err++; $display("FAIL rnd_req cyc %0d got %0h want %0h", i, mem_req, m_req); end
      if (m_req) begin
        n_cmp++; if (mem_addr !== m_addr) begin n_err++; $display("FAIL rnd_addr cyc %0d got %0h want %0h", i, mem_addr, m_addr); end
      end
      n_cmp++; if (instr_valid !== (m_q.size() != 0)) begin
        n_err++; $display("FAIL rnd_valid cyc %0d got %0h want %0h", i, instr_valid, m_q.size() != 0);
      end
      if (m_q.size() != 0) begin
        hd = m_q[0];
        n_cmp++; if (instr !== hd[31:0] || instr_pc !== hd[63:32]) begin
          n_err++; $display("FAIL rnd_head cyc %0d instr %0h pc %0h want %0h %0h", i, instr, instr_pc, hd[31:0], hd[63:32]);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_redirect_stale();
    test_redirect_ack_take();
    test_wrap();
    test_bypass_latency();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
